trail_writer: RTL and testbench
===============================

Name: trail_writer

Overview:
Upstream producer for the frame buffer (frameRAM) read by the compositing stage. It drives the frame buffer write port (Data_In, write_address, WE) with all screen content. On reset or request it clears the playfield and draws the arena wall. On each frame tick it paints the current red and blue bike head positions as trail pixels.

Parameters:
H_WORDS, 320, frame buffer words per line (2 pixels per word)
V_LINES, 480, visible lines
BG_COLOR, 4'h0, background colour enum
RED_COLOR, 4'h4, red trail colour enum
BLUE_COLOR, 4'h6, blue trail colour enum
WALL_COLOR, 4'h8, arena wall colour enum

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  ~60 Hz frame tick; level signal, asynchronous to Clk
game_active  in  1  1 = paint trails on frame ticks
clear_req  in  1  single-cycle pulse; request a playfield clear
red_x, red_y  in  10 each  red bike head pixel position
blue_x, blue_y  in  10 each  blue bike head pixel position
Data_In  out  16  frame buffer write data
write_address  out  19  frame buffer word address
WE  out  1  frame buffer write enable
busy  out  1  high while in CLEAR

Behaviour:
- Reset asserted: state=CLEAR, clear counter=0, WE=0, write_address=0, Data_In=0, busy=1, sync/edge flops=0, pending_clear=0. All outputs are registered.
- Word format: {4'h0, c, 4'h0, c}. Nibble [3:0] holds the even-X pixel and [11:8] the odd-X pixel. Both get the same colour, so trails are 2 px wide horizontally.
- Address: write_address = y*H_WORDS + x/2, computed as (y<<8)+(y<<6)+(x>>1), zero-extended to 19 bits. The maximum is 153599.
- frame_clk path: 2-flop synchroniser, then a rising-edge detect producing a 1-cycle frame_tick. The tick lags the frame_clk rising edge by 3 Clk cycles.
- States:
  - CLEAR: each cycle WE=1, address=counter, and the counter increments. A word is WALL_COLOR if its line is 0 or V_LINES-1, or its column (counter mod H_WORDS) is 0 or H_WORDS-1. Otherwise it is BG_COLOR. The line/column are tracked with separate counters, not a divider. After writing word H_WORDS*V_LINES-1 the next state is WAIT. The clear takes 153600 write cycles and busy=1 throughout.
  - WAIT: WE=0, busy=0. If pending_clear or clear_req is set, go to CLEAR, reset the counters, and clear pending_clear. Clear has priority over paint. Else if frame_tick and game_active, latch all four positions and go to WR_RED.
  - WR_RED: if the latched red position is in range (x<640 and y<480), issue a 1-cycle WE with RED_COLOR at its address. Otherwise WE=0. Next state is WR_BLUE.
  - WR_BLUE: same for blue with BLUE_COLOR. Next state is WAIT.
- A frame tick always yields exactly 2 cycles of activity (WR_RED, WR_BLUE), with at most 2 WE pulses.
- Positions are latched on entry to WR_RED, so bike movement mid-sequence has no effect.
- frame_tick during CLEAR, WR_RED or WR_BLUE is dropped, not queued.
- clear_req during WR_RED or WR_BLUE sets pending_clear, which is serviced on return to WAIT.
- clear_req during CLEAR is ignored; the clear continues without restarting.
- If both bikes share a word, blue overwrites red (later write wins).
- Reset asserted mid-CLEAR or mid-paint: immediate return to reset values, then a full clear restarts.
- Write addresses always stay in range; no wrap-around is possible.

Test Plan:
- Reset pulse, run 153600 cycles: busy=1 throughout. Words 0, 319, 320 and 153599 = 16'h0808. Word 321 = 16'h0000. Exactly 153600 WE pulses, then busy=0.
- After clear, game_active=1, red=(100,50), blue=(401,200), one frame_clk rise: WE at addr 16050 with data 16'h0404, then WE the next cycle at addr 64200 with data 16'h0606. No further WE.
- red=(640,10), blue=(5,479), tick: no red write. Blue WE at addr 153282 with data 16'h0606. Exactly 1 WE pulse.
- game_active=0 with frame_clk toggling 3 times: zero WE pulses.
- clear_req pulse coincident with WR_RED: red and blue writes complete, then CLEAR starts on the following cycle, busy=1, 153600 writes.
- Reset asserted at clear word 70000: outputs return to reset values immediately. After release, the clear restarts at address 0.

Source files
------------

// File: rtl/trail_writer.sv
// Frame buffer producer: clears the playfield and draws the arena wall, then
// paints red and blue bike head pixels as trail words on each frame tick.
module trail_writer #(
    parameter int         H_WORDS    = 320,
    parameter int         V_LINES    = 480,
    parameter logic [3:0] BG_COLOR   = 4'h0,
    parameter logic [3:0] RED_COLOR  = 4'h4,
    parameter logic [3:0] BLUE_COLOR = 4'h6,
    parameter logic [3:0] WALL_COLOR = 4'h8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        game_active,
    input  logic        clear_req,
    input  logic [9:0]  red_x,
    input  logic [9:0]  red_y,
    input  logic [9:0]  blue_x,
    input  logic [9:0]  blue_y,
    output logic [15:0] Data_In,
    output logic [18:0] write_address,
    output logic        WE,
    output logic        busy
);

    localparam int TOTAL_WORDS = H_WORDS * V_LINES;
    localparam int CNT_W       = $clog2(TOTAL_WORDS);
    localparam int COL_W       = $clog2(H_WORDS);
    localparam int LINE_W      = $clog2(V_LINES);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_WAIT,
        ST_WR_RED,
        ST_WR_BLUE
    } state_t;

    state_t state, next_state;

    logic              frame_sync1, frame_sync2, frame_prev, frame_tick;
    logic [CNT_W-1:0]  clear_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              pending_clear;
    logic [9:0]        lat_red_x, lat_red_y, lat_blue_x, lat_blue_y;

    logic              we_next, busy_next;
    logic [18:0]       addr_next;
    logic [15:0]       data_next;
    logic              start_clear, latch_pos, set_pending, last_word, on_wall;

    // Both nibble pixels of a word carry the same colour, giving 2 px wide trails.
    function automatic logic [15:0] make_word(input logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

    // For the 320-word line this is (y<<8)+(y<<6)+(x>>1).
    function automatic logic [18:0] word_addr(input logic [9:0] x, input logic [9:0] y);
        return 19'(y) * 19'(H_WORDS) + 19'(x[9:1]);
    endfunction

    function automatic logic pos_ok(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} < 11'(2 * H_WORDS)) && ({1'b0, y} < 11'(V_LINES));
    endfunction

    // frame_clk is asynchronous: two-flop synchroniser, then registered rising-edge pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_sync1 <= 1'b0;
            frame_sync2 <= 1'b0;
            frame_prev  <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_prev  <= frame_sync2;
            frame_tick  <= frame_sync2 & ~frame_prev;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_CLEAR;
        else       state <= next_state;
    end

    assign last_word = (clear_cnt == CNT_W'(TOTAL_WORDS - 1));
    assign on_wall   = (line_cnt == '0) || (line_cnt == LINE_W'(V_LINES - 1)) ||
                       (col_cnt == '0)  || (col_cnt == COL_W'(H_WORDS - 1));

    always_comb begin
        next_state  = state;
        we_next     = 1'b0;
        addr_next   = write_address;
        data_next   = Data_In;
        start_clear = 1'b0;
        latch_pos   = 1'b0;
        set_pending = 1'b0;
        case (state)
            ST_CLEAR: begin
                we_next   = 1'b1;
                addr_next = 19'(clear_cnt);
                data_next = make_word(on_wall ? WALL_COLOR : BG_COLOR);
                if (last_word) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (pending_clear || clear_req) begin
                    next_state  = ST_CLEAR;
                    start_clear = 1'b1;
                end else if (frame_tick && game_active) begin
                    next_state = ST_WR_RED;
                    latch_pos  = 1'b1;
                end
            end
            ST_WR_RED: begin
                set_pending = clear_req;
                if (pos_ok(lat_red_x, lat_red_y)) begin
                    we_next   = 1'b1;
                    addr_next = word_addr(lat_red_x, lat_red_y);
                    data_next = make_word(RED_COLOR);
                end
                next_state = ST_WR_BLUE;
            end
            ST_WR_BLUE: begin
                set_pending = clear_req;
                if (pos_ok(lat_blue_x, lat_blue_y)) begin
                    we_next   = 1'b1;
                    addr_next = word_addr(lat_blue_x, lat_blue_y);
                    data_next = make_word(BLUE_COLOR);
                end
                next_state = ST_WAIT;
            end
            default: next_state = ST_CLEAR;
        endcase
        busy_next = (state == ST_CLEAR) || (next_state == ST_CLEAR);
    end

    // Line/column counters run alongside the linear counter so no divider is needed.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clear_cnt <= '0;
            col_cnt   <= '0;
            line_cnt  <= '0;
        end else if (start_clear) begin
            clear_cnt <= '0;
            col_cnt   <= '0;
            line_cnt  <= '0;
        end else if (state == ST_CLEAR && !last_word) begin
            clear_cnt <= clear_cnt + 1'b1;
            if (col_cnt == COL_W'(H_WORDS - 1)) begin
                col_cnt  <= '0;
                line_cnt <= line_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pending_clear <= 1'b0;
            lat_red_x     <= '0;
            lat_red_y     <= '0;
            lat_blue_x    <= '0;
            lat_blue_y    <= '0;
        end else begin
            if (start_clear)      pending_clear <= 1'b0;
            else if (set_pending) pending_clear <= 1'b1;
            if (latch_pos) begin
                lat_red_x  <= red_x;
                lat_red_y  <= red_y;
                lat_blue_x <= blue_x;
                lat_blue_y <= blue_y;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            WE            <= 1'b0;
            write_address <= '0;
            Data_In       <= '0;
            busy          <= 1'b1;
        end else begin
            WE            <= we_next;
            write_address <= addr_next;
            Data_In       <= data_next;
            busy          <= busy_next;
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Randomised bench for trail_writer on a reduced playfield, checked against a
// frame buffer image model computed directly from the wall and trail rules.
module tb_trail_writer;

    localparam int H     = 20;
    localparam int V     = 12;
    localparam int TOTAL = H * V;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        game_active = 1'b0;
    logic        clear_req = 1'b0;
    logic [9:0]  red_x = '0, red_y = '0, blue_x = '0, blue_y = '0;
    logic [15:0] Data_In;
    logic [18:0] write_address;
    logic        WE;
    logic        busy;

    typedef struct {
        logic [18:0] addr;
        logic [15:0] data;
        logic        busy;
    } wr_t;

    wr_t         wr_log[$];
    logic [15:0] dut_mem   [TOTAL];
    logic [15:0] model_mem [TOTAL];
    int          bad_addr = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    trail_writer #(.H_WORDS(H), .V_LINES(V)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_active(game_active),
        .clear_req(clear_req), .red_x(red_x), .red_y(red_y), .blue_x(blue_x),
        .blue_y(blue_y), .Data_In(Data_In), .write_address(write_address),
        .WE(WE), .busy(busy)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (WE === 1'b1) begin
            wr_log.push_back('{write_address, Data_In, busy});
            if (int'(write_address) < TOTAL) dut_mem[int'(write_address)] = Data_In;
            else bad_addr++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] wordOf(input logic [3:0] c);
        return {4'h0, c, 4'h0, c};
    endfunction

    function automatic logic [15:0] clearWord(input int a);
        int line = a / H;
        int col  = a % H;
        return (line == 0 || line == V - 1 || col == 0 || col == H - 1) ? wordOf(4'h8) : wordOf(4'h0);
    endfunction

    task automatic waitClearDone(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
        checkOutput({tag, "_busy_rise"}, 32'(busy), 1);
        n = 0;
        while (busy !== 1'b0 && n < TOTAL + 20) begin @(negedge Clk); n++; end
        checkOutput({tag, "_busy_fall"}, 32'(busy), 0);
        repeat (3) @(negedge Clk);
    endtask

    task automatic checkClearLog(input string tag, input int start_idx);
        int errs = 0;
        checkOutput({tag, "_count"}, 32'(wr_log.size() - start_idx), TOTAL);
        for (int i = 0; i < TOTAL; i++) begin
            if (start_idx + i < wr_log.size()) begin
                if (wr_log[start_idx + i].addr !== 19'(i) || wr_log[start_idx + i].data !== clearWord(i) ||
                    wr_log[start_idx + i].busy !== 1'b1) errs++;
            end else begin
                errs++;
            end
            model_mem[i] = clearWord(i);
        end
        checkOutput({tag, "_content"}, 32'(errs), 0);
    endtask

    // One frame_clk pulse; positions are scrambled mid-sequence to confirm latching.
    task automatic applyStimulus(input logic [9:0] rx, ry, bx, by, input logic act, input string tag);
        logic [18:0] exp_addr[$];
        logic [15:0] exp_data[$];
        red_x = rx; red_y = ry; blue_x = bx; blue_y = by; game_active = act;
        if (act && rx < 2 * H && ry < V) begin
            exp_addr.push_back(19'(ry * H + rx / 2)); exp_data.push_back(wordOf(4'h4));
        end
        if (act && bx < 2 * H && by < V) begin
            exp_addr.push_back(19'(by * H + bx / 2)); exp_data.push_back(wordOf(4'h6));
        end
        wr_log.delete();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        red_x = 10'($urandom_range(0, 2 * H - 1)); red_y = 10'($urandom_range(0, V - 1));
        blue_x = 10'($urandom_range(0, 2 * H - 1)); blue_y = 10'($urandom_range(0, V - 1));
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        checkOutput({tag, "_we_count"}, 32'(wr_log.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < wr_log.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wr_log[i].addr), 32'(exp_addr[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wr_log[i].data), 32'(exp_data[i]));
            if (wr_log[i].busy !== 1'b0) checkOutput($sformatf("%s_busy%0d", tag, i), 32'(wr_log[i].busy), 0);
            model_mem[int'(exp_addr[i])] = exp_data[i];
        end
    endtask

    task automatic checkMemory(input string tag);
        int errs = 0;
        for (int i = 0; i < TOTAL; i++) if (dut_mem[i] !== model_mem[i]) errs++;
        checkOutput({tag, "_mem"}, 32'(errs), 0);
        checkOutput({tag, "_bad_addr"}, 32'(bad_addr), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        checkOutput("rst_we", 32'(WE), 0);
        checkOutput("rst_addr", 32'(write_address), 0);
        checkOutput("rst_data", 32'(Data_In), 0);
        checkOutput("rst_busy", 32'(busy), 1);
        Reset = 1'b0;
        waitClearDone("init_clear");
        checkClearLog("init_clear", 0);
        checkOutput("word_first", 32'(dut_mem[0]), 32'h0808);
        checkOutput("word_line_end", 32'(dut_mem[H - 1]), 32'h0808);
        checkOutput("word_line1_start", 32'(dut_mem[H]), 32'h0808);
        checkOutput("word_last", 32'(dut_mem[TOTAL - 1]), 32'h0808);
        checkOutput("word_interior", 32'(dut_mem[H + 1]), 32'h0000);
        wr_log.delete();
        repeat (10) @(negedge Clk);
        checkOutput("idle_no_we", 32'(wr_log.size()), 0);

        applyStimulus(10'd10, 10'd3, 10'd21, 10'd7, 1'b1, "both_in");
        applyStimulus(10'(2 * H), 10'd3, 10'd5, 10'(V - 1), 1'b1, "red_out");
        applyStimulus(10'd6, 10'd4, 10'd7, 10'd4, 1'b1, "same_word");
        applyStimulus(10'd3, 10'(V), 10'(2 * H + 1), 10'd2, 1'b1, "both_out");
        for (int i = 0; i < 3; i++) applyStimulus(10'd8, 10'd2, 10'd9, 10'd5, 1'b0, $sformatf("inactive%0d", i));
        for (int i = 0; i < 25; i++)
            applyStimulus(10'($urandom_range(0, 2 * H + 5)), 10'($urandom_range(0, V + 2)),
                          10'($urandom_range(0, 2 * H + 5)), 10'($urandom_range(0, V + 2)),
                          1'($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
        checkMemory("after_paint");

        // clear_req lands on the WR_RED cycle: both paints finish, then a full clear.
        red_x = 10'd12; red_y = 10'd5; blue_x = 10'd30; blue_y = 10'd8; game_active = 1'b1;
        wr_log.delete();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1 clear_req = 1'b1;
        @(posedge Clk);
        #1 clear_req = 1'b0;
        waitClearDone("clr_paint");
        frame_clk = 1'b0;
        checkOutput("clr_paint_red_addr", 32'(wr_log[0].addr), 32'(5 * H + 6));
        checkOutput("clr_paint_red_data", 32'(wr_log[0].data), 32'h0404);
        checkOutput("clr_paint_blue_addr", 32'(wr_log[1].addr), 32'(8 * H + 15));
        checkOutput("clr_paint_blue_data", 32'(wr_log[1].data), 32'h0606);
        checkClearLog("clr_paint", 2);
        checkMemory("after_clr_paint");

        // Clear started mid-game, interrupted by reset, with an ignored clear_req inside.
        wr_log.delete();
        @(negedge Clk) clear_req = 1'b1;
        @(negedge Clk) clear_req = 1'b0;
        n = 0;
        while (wr_log.size() < 60 && n < 200) begin @(negedge Clk); n++; end
        checkOutput("mid_clear_progress", 32'(wr_log.size() >= 60), 1);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        checkOutput("midrst_we", 32'(WE), 0);
        checkOutput("midrst_addr", 32'(write_address), 0);
        checkOutput("midrst_data", 32'(Data_In), 0);
        checkOutput("midrst_busy", 32'(busy), 1);
        @(negedge Clk);
        Reset = 1'b0;
        wr_log.delete();
        repeat (50) @(negedge Clk);
        clear_req = 1'b1;
        @(negedge Clk) clear_req = 1'b0;
        waitClearDone("restart_clear");
        checkClearLog("restart_clear", 0);
        checkMemory("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
